c1541_track_ctrl: RTL and testbench
===================================

C1541_TRACK_CTRL -- requirements
Module: c1541_track_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CNT, default 20000, head-settle delay in ce ticks (20 ms at 1 MHz).
REQ-002 SHALL have parameter MAX_HTRACK, default 83, highest reachable half-track (track 42).
REQ-003 SHALL have one clock, clk32, and an asynchronous active-low reset, reset_n.
REQ-004 SHALL have ports:
- clk32  in  1  system clock.
- reset_n  in  1  async reset, active low.
- ce  in  1  1 MHz drive-cycle enable.
- stp  in  2  VIA stepper phase.
- mtr  in  1  spindle motor on.
- byte_wr  in  1  one-clk pulse: byte written into track buffer.
- img_mounted  in  1  one-clk pulse: new image inserted.
- img_readonly  in  1  image write-protected.
- sd_ack  in  1  loader accepted request.
- sd_done  in  1  one-clk pulse: loader transfer finished.
- half_track  out  7  head position, 0..MAX_HTRACK.
- tr00_sense_n  out  1  low when half_track==0.
- wps_n  out  1  low when img_readonly=1.
- busy  out  1  track buffer invalid; disk datapath idles.
- sd_rd_req  out  1  load track into buffer.
- sd_wr_req  out  1  save buffer to image.
- sd_track  out  6  track index for request, 0..41.

Function
REQ-005 SHALL sample stp only on ce with mtr=1; delta=(stp_new-stp_old) mod 4.
REQ-006 delta 1 SHALL increment half_track, saturating at MAX_HTRACK; delta 3 SHALL decrement it, saturating at 0; delta 0 or 2 SHALL leave it unchanged.
REQ-007 SHALL update stp_old on every ce, whether or not mtr=1.
REQ-008 Track index SHALL be half_track[6:1]; odd half-tracks read the lower track.
REQ-009 FSM states SHALL be IDLE, SETTLE, SAVE_REQ, SAVE_WAIT, LOAD_REQ, LOAD_WAIT.
REQ-010 SHALL enter SETTLE with counter=SETTLE_CNT on:
- a half_track change from any state except SAVE_* or LOAD_*;
- img_mounted.
REQ-011 In SETTLE, the counter SHALL decrement on ce; any further step SHALL reload it.
REQ-012 When the SETTLE counter reaches 0: if dirty=1, go to SAVE_REQ; otherwise go to LOAD_REQ.
REQ-013 In IDLE, mtr falling while dirty=1 SHALL go to SAVE_REQ, flushing the buffer on motor stop.
REQ-014 SAVE_REQ SHALL:
- assert sd_wr_req with sd_track=loaded_track, held until sd_ack;
- then go to SAVE_WAIT.
REQ-015 In SAVE_WAIT, sd_done SHALL clear dirty, then go to LOAD_REQ if track!=loaded_track, otherwise to IDLE.
REQ-016 LOAD_REQ SHALL:
- assert sd_rd_req with sd_track=current track, held until sd_ack;
- then go to LOAD_WAIT.
REQ-017 In LOAD_WAIT, sd_done SHALL set loaded_track=track and loaded_valid=1.
REQ-018 After LOAD_WAIT completes: if half_track moved during SAVE_*/LOAD_*, go to SETTLE; otherwise go to IDLE.
REQ-019 sd_rd_req and sd_wr_req SHALL never be asserted together; sd_track SHALL be stable while either is high.
REQ-020 busy SHALL be 1 whenever state!=IDLE or loaded_valid=0.
REQ-021 dirty SHALL set on byte_wr only when busy=0 and img_readonly=0; otherwise byte_wr is ignored.
REQ-022 img_mounted SHALL clear dirty and loaded_valid in the same cycle, discarding unsaved data; if mid-handshake, the current request SHALL complete before the reload.
REQ-023 On simultaneous img_mounted and step, both effects SHALL apply; the single resulting SETTLE covers both.
REQ-024 sd_ack or sd_done in a state not waiting for it SHALL be ignored.

Reset
REQ-025 reset_n low SHALL asynchronously force:
- half_track=34 (track 18), stp_old=0;
- state=IDLE, dirty=0, loaded_valid=0, counter=0;
- sd_rd_req=0, sd_wr_req=0, sd_track=0, busy=1.
REQ-026 After reset release, no request SHALL issue until the first img_mounted or step.

Structure
REQ-027 Package c1541_pkg SHALL hold the FSM state enum, HTRACK_RESET=34, and the MAX_HTRACK/SETTLE_CNT defaults.
REQ-028 Stepper decode and half_track saturation SHALL be a sub-module, c1541_step_decode.

Verification
REQ-029 Reset, then img_mounted -> after 20000 ce: sd_rd_req=1 with sd_track=17; after ack+done: busy=0.
REQ-030 Idle with mtr=1, stp 0->1->2 on two ce -> half_track=36; after settle: load issued with sd_track=18.
REQ-031 byte_wr with busy=0, then step up twice -> sd_wr_req (sd_track=17) precedes sd_rd_req (sd_track=18); dirty=0 after save.
REQ-032 half_track=0, stp decrement -> half_track stays 0, tr00_sense_n=0, no request.
REQ-033 img_readonly=1 with byte_wr pulses, then mtr falls -> wps_n=0, no sd_wr_req.
REQ-034 Step during LOAD_WAIT -> the load completes, then SETTLE, then a second load with the new track; reset_n low mid-LOAD_WAIT -> all requests 0 immediately.

Source files
------------

// File: rtl/c1541_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | c1541_pkg                                                                  |
// | Shared types and constants for the 1541 track-buffer controller.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package c1541_pkg;

    localparam int HTRACK_RESET       = 34;
    localparam int MAX_HTRACK_DEFAULT = 83;
    localparam int SETTLE_CNT_DEFAULT = 20000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_SAVE_REQ  = 3'd2,
        ST_SAVE_WAIT = 3'd3,
        ST_LOAD_REQ  = 3'd4,
        ST_LOAD_WAIT = 3'd5
    } track_state_t;

    // States in which a loader handshake is outstanding.
    function automatic logic is_xfer(input track_state_t s);
        return (s == ST_SAVE_REQ) || (s == ST_SAVE_WAIT) ||
               (s == ST_LOAD_REQ) || (s == ST_LOAD_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/c1541_step_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | c1541_step_decode                                                          |
// | Stepper-phase decoder; tracks the saturating head half-track position.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module c1541_step_decode
    import c1541_pkg::*;
#(
    parameter int MAX_HTRACK = MAX_HTRACK_DEFAULT
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       mtr,
    input  logic [1:0] stp,
    output logic [6:0] half_track,
    output logic       moved
);

    logic [1:0] r_stp_old;
    logic [1:0] w_delta;
    logic [6:0] r_half_track;
    logic [6:0] w_half_track_nxt;

    always_comb begin
        w_delta          = stp - r_stp_old;
        w_half_track_nxt = r_half_track;
        if (ce && mtr) begin
            if (w_delta == 2'd1 && r_half_track < 7'(MAX_HTRACK))
                w_half_track_nxt = r_half_track + 7'd1;
            else if (w_delta == 2'd3 && r_half_track != 7'd0)
                w_half_track_nxt = r_half_track - 7'd1;
        end
    end

    // Phase history follows the VIA even with the motor off.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_stp_old    <= 2'd0;
            r_half_track <= 7'(HTRACK_RESET);
        end else begin
            if (ce)
                r_stp_old <= stp;
            r_half_track <= w_half_track_nxt;
        end
    end

    assign half_track = r_half_track;
    assign moved      = (w_half_track_nxt != r_half_track);

endmodule
`default_nettype wire

// File: rtl/c1541_track_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | c1541_track_ctrl                                                           |
// | Head positioning and track-buffer load/save sequencing for a 1541 drive.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module c1541_track_ctrl
    import c1541_pkg::*;
#(
    parameter int SETTLE_CNT = SETTLE_CNT_DEFAULT,
    parameter int MAX_HTRACK = MAX_HTRACK_DEFAULT
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [1:0] stp,
    input  logic       mtr,
    input  logic       byte_wr,
    input  logic       img_mounted,
    input  logic       img_readonly,
    input  logic       sd_ack,
    input  logic       sd_done,
    output logic [6:0] half_track,
    output logic       tr00_sense_n,
    output logic       wps_n,
    output logic       busy,
    output logic       sd_rd_req,
    output logic       sd_wr_req,
    output logic [5:0] sd_track
);

    localparam int c_cnt_w = (SETTLE_CNT < 1) ? 1 : $clog2(SETTLE_CNT + 1);

    logic [6:0]         w_half_track;
    logic               w_moved;
    logic [5:0]         w_track;
    track_state_t       r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_dirty, w_dirty_nxt;
    logic               r_loaded_valid, w_loaded_valid_nxt;
    logic [5:0]         r_loaded_track, w_loaded_track_nxt;
    logic [5:0]         r_sd_track, w_sd_track_nxt;
    logic               r_resettle, w_resettle_nxt;
    logic               r_mtr_d;
    logic               w_busy;
    logic               w_settle;

    c1541_step_decode #(
        .MAX_HTRACK (MAX_HTRACK)
    ) u_step_decode (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .ce         (ce),
        .mtr        (mtr),
        .stp        (stp),
        .half_track (w_half_track),
        .moved      (w_moved)
    );

    assign w_track = w_half_track[6:1];
    assign w_busy  = (r_state != ST_IDLE) || !r_loaded_valid;

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_dirty_nxt        = r_dirty;
        w_loaded_valid_nxt = r_loaded_valid;
        w_loaded_track_nxt = r_loaded_track;
        w_sd_track_nxt     = r_sd_track;
        w_resettle_nxt     = r_resettle;
        w_settle           = 1'b0;

        if (byte_wr && !w_busy && !img_readonly)
            w_dirty_nxt = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (r_mtr_d && !mtr && r_dirty) begin
                    w_state_nxt    = ST_SAVE_REQ;
                    w_sd_track_nxt = r_loaded_track;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    if (r_dirty) begin
                        w_state_nxt    = ST_SAVE_REQ;
                        w_sd_track_nxt = r_loaded_track;
                    end else begin
                        w_state_nxt    = ST_LOAD_REQ;
                        w_sd_track_nxt = w_track;
                    end
                end else if (ce) begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            ST_SAVE_REQ: begin
                if (sd_ack)
                    w_state_nxt = ST_SAVE_WAIT;
            end
            ST_SAVE_WAIT: begin
                if (sd_done) begin
                    w_dirty_nxt = 1'b0;
                    // An invalidated buffer (image swapped mid-save) always needs a reload.
                    if (w_track != r_loaded_track || !r_loaded_valid) begin
                        w_state_nxt    = ST_LOAD_REQ;
                        w_sd_track_nxt = w_track;
                    end else if (r_resettle) begin
                        w_settle = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_LOAD_REQ: begin
                if (sd_ack)
                    w_state_nxt = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                if (sd_done) begin
                    w_loaded_track_nxt = r_sd_track;
                    w_loaded_valid_nxt = 1'b1;
                    if (r_resettle)
                        w_settle = 1'b1;
                    else
                        w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Moves or swaps during a handshake are remembered and honoured once it ends.
        if (w_moved || img_mounted) begin
            if (is_xfer(r_state) && is_xfer(w_state_nxt) && !w_settle)
                w_resettle_nxt = 1'b1;
            else
                w_settle = 1'b1;
        end

        if (img_mounted) begin
            w_dirty_nxt        = 1'b0;
            w_loaded_valid_nxt = 1'b0;
        end

        if (w_settle) begin
            w_state_nxt    = ST_SETTLE;
            w_cnt_nxt      = c_cnt_w'(SETTLE_CNT);
            w_resettle_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_dirty        <= 1'b0;
            r_loaded_valid <= 1'b0;
            r_loaded_track <= 6'd0;
            r_sd_track     <= 6'd0;
            r_resettle     <= 1'b0;
            r_mtr_d        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_dirty        <= w_dirty_nxt;
            r_loaded_valid <= w_loaded_valid_nxt;
            r_loaded_track <= w_loaded_track_nxt;
            r_sd_track     <= w_sd_track_nxt;
            r_resettle     <= w_resettle_nxt;
            r_mtr_d        <= mtr;
        end
    end

    assign half_track   = w_half_track;
    assign tr00_sense_n = (w_half_track != 7'd0);
    assign wps_n        = !img_readonly;
    assign busy         = w_busy;
    assign sd_rd_req    = (r_state == ST_LOAD_REQ);
    assign sd_wr_req    = (r_state == ST_SAVE_REQ);
    assign sd_track     = r_sd_track;

endmodule
`default_nettype wire

// File: tb/tb_c1541_track_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_c1541_track_ctrl                                                        |
// | Self-checking bench: vector table, handshake sequences, random stepping.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_c1541_track_ctrl;

    localparam int SC = 16;
    localparam int MH = 83;

    logic       clk32 = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0, mtr = 1'b0, byte_wr = 1'b0, img_mounted = 1'b0;
    logic       img_readonly = 1'b0, sd_ack = 1'b0, sd_done = 1'b0;
    logic [1:0] stp = 2'd0;
    logic [6:0] half_track;
    logic       tr00_sense_n, wps_n, busy, sd_rd_req, sd_wr_req;
    logic [5:0] sd_track;

    int  n_vec = 0;
    int  n_bad = 0;
    bit  ce_auto = 1'b0;

    typedef struct {
        logic       ce;
        logic       mtr;
        logic [1:0] stp;
        int         ht;
    } vec_t;
    vec_t tbl [10];

    always #5 clk32 = ~clk32;

    c1541_track_ctrl #(
        .SETTLE_CNT (SC),
        .MAX_HTRACK (MH)
    ) dut (
        .clk32        (clk32),
        .reset_n      (reset_n),
        .ce           (ce),
        .stp          (stp),
        .mtr          (mtr),
        .byte_wr      (byte_wr),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .sd_ack       (sd_ack),
        .sd_done      (sd_done),
        .half_track   (half_track),
        .tr00_sense_n (tr00_sense_n),
        .wps_n        (wps_n),
        .busy         (busy),
        .sd_rd_req    (sd_rd_req),
        .sd_wr_req    (sd_wr_req),
        .sd_track     (sd_track)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk32);
        #1;
        if (ce_auto)
            ce = ~ce;
    endtask

    task automatic do_reset();
        ce_auto = 1'b0; ce = 1'b0; mtr = 1'b0; stp = 2'd0; byte_wr = 1'b0;
        img_mounted = 1'b0; img_readonly = 1'b0; sd_ack = 1'b0; sd_done = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk32);
        #1;
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic step(input bit up);
        ce_auto = 1'b0;
        stp = up ? stp + 2'd1 : stp - 2'd1;
        ce = 1'b1; cyc();
        ce = 1'b0; cyc();
    endtask

    task automatic pulse_mount();
        img_mounted = 1'b1; cyc(); img_mounted = 1'b0;
    endtask

    // ces counts ce ticks sampled strictly before the edge that raised the request.
    task automatic wait_req(input bit wr, input int maxc, output int ces, output bit ok, output bit other);
        bit ce_s;
        ces = 0; ok = 1'b0; other = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            ce_s = ce;
            cyc();
            if (wr ? sd_rd_req : sd_wr_req)
                other = 1'b1;
            if (wr ? sd_wr_req : sd_rd_req) begin
                ok = 1'b1;
                break;
            end
            if (ce_s)
                ces++;
        end
    endtask

    task automatic serve(input bit wr, input int exp_trk, input string nm, output int ces);
        bit ok, other;
        ce_auto = 1'b1;
        wait_req(wr, 8 * SC + 20, ces, ok, other);
        chk({nm, " request seen"}, int'(ok), 1);
        chk({nm, " opposite request"}, int'(other), 0);
        if (ok) begin
            chk({nm, " sd_track"}, int'(sd_track), exp_trk);
            cyc(); cyc();
            chk({nm, " request held"}, int'(wr ? sd_wr_req : sd_rd_req), 1);
            chk({nm, " sd_track stable"}, int'(sd_track), exp_trk);
            sd_ack = 1'b1; cyc(); sd_ack = 1'b0;
            chk({nm, " request dropped"}, int'(wr ? sd_wr_req : sd_rd_req), 0);
            cyc(); cyc();
            sd_done = 1'b1; cyc(); sd_done = 1'b0;
        end
        ce_auto = 1'b0;
        ce = 1'b0;
    endtask

    task automatic watch_quiet(input int n, input string nm);
        bit any;
        any = 1'b0;
        ce_auto = 1'b1;
        repeat (n) begin
            cyc();
            if (sd_rd_req || sd_wr_req)
                any = 1'b1;
        end
        ce_auto = 1'b0;
        ce = 1'b0;
        chk(nm, int'(any), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  ces;
        bit  ok, other;
        int  m_ht, prev_ht;
        logic [1:0] m_old;
        logic prev_rd, prev_wr;
        logic [5:0] prev_trk;

        // stp history starts at 0 after reset; half_track starts at 34.
        tbl[0] = '{1'b1, 1'b1, 2'd1, 35};
        tbl[1] = '{1'b1, 1'b1, 2'd2, 36};
        tbl[2] = '{1'b0, 1'b1, 2'd3, 36};
        tbl[3] = '{1'b1, 1'b1, 2'd3, 37};
        tbl[4] = '{1'b1, 1'b1, 2'd1, 37};
        tbl[5] = '{1'b1, 1'b1, 2'd0, 36};
        tbl[6] = '{1'b1, 1'b0, 2'd1, 36};
        tbl[7] = '{1'b1, 1'b1, 2'd1, 36};
        tbl[8] = '{1'b1, 1'b1, 2'd0, 35};
        tbl[9] = '{1'b1, 1'b1, 2'd3, 34};

        // Reset state
        do_reset();
        chk("reset half_track", int'(half_track), 34);
        chk("reset tr00_sense_n", int'(tr00_sense_n), 1);
        chk("reset busy", int'(busy), 1);
        chk("reset sd_rd_req", int'(sd_rd_req), 0);
        chk("reset sd_wr_req", int'(sd_wr_req), 0);
        chk("reset sd_track", int'(sd_track), 0);
        chk("reset wps_n", int'(wps_n), 1);

        for (int i = 0; i < 10; i++) begin
            ce = tbl[i].ce; mtr = tbl[i].mtr; stp = tbl[i].stp;
            cyc();
            chk($sformatf("table[%0d] half_track", i), int'(half_track), tbl[i].ht);
            chk($sformatf("table[%0d] tr00_sense_n", i), int'(tr00_sense_n), int'(tbl[i].ht != 0));
        end
        ce = 1'b0; mtr = 1'b0;

        // Quiet after reset, then first mount loads track 17
        do_reset();
        mtr = 1'b1;
        watch_quiet(4 * SC, "no request before mount");
        chk("busy before mount", int'(busy), 1);
        pulse_mount();
        serve(1'b0, 17, "mount load", ces);
        chk("mount settle ce count", ces, SC);
        chk("busy after mount load", int'(busy), 0);

        // Two steps up -> 36, load track 18
        step(1'b1);
        step(1'b1);
        chk("two steps half_track", int'(half_track), 36);
        chk("busy during settle", int'(busy), 1);
        serve(1'b0, 18, "step load", ces);
        chk("step settle ce count", ces, SC);
        chk("busy after step load", int'(busy), 0);

        // Dirty buffer saved before the new track loads
        do_reset();
        pulse_mount();
        serve(1'b0, 17, "dirty setup load", ces);
        mtr = 1'b1;
        byte_wr = 1'b1; cyc(); byte_wr = 1'b0;
        step(1'b1);
        step(1'b1);
        serve(1'b1, 17, "dirty save", ces);
        serve(1'b0, 18, "load after save", ces);
        chk("busy after save+load", int'(busy), 0);
        mtr = 1'b0;
        watch_quiet(2 * SC, "no save once clean");
        mtr = 1'b1; cyc();
        byte_wr = 1'b1; cyc(); byte_wr = 1'b0;
        mtr = 1'b0;
        serve(1'b1, 18, "motor stop flush", ces);
        chk("busy after flush", int'(busy), 0);
        watch_quiet(2 * SC, "no reload after flush");

        // Saturation at track 0 and at MAX_HTRACK
        do_reset();
        pulse_mount();
        serve(1'b0, 17, "sat setup load", ces);
        mtr = 1'b1;
        repeat (34) step(1'b0);
        chk("down to zero half_track", int'(half_track), 0);
        chk("zero tr00_sense_n", int'(tr00_sense_n), 0);
        serve(1'b0, 0, "load track 0", ces);
        step(1'b0);
        chk("saturate low half_track", int'(half_track), 0);
        chk("saturate low tr00_sense_n", int'(tr00_sense_n), 0);
        chk("saturate low busy", int'(busy), 0);
        watch_quiet(3 * SC, "no request on saturated step");
        repeat (MH + 6) step(1'b1);
        chk("saturate high half_track", int'(half_track), MH);
        chk("high tr00_sense_n", int'(tr00_sense_n), 1);
        serve(1'b0, MH / 2, "load top track", ces);

        // Write-protected image ignores writes
        do_reset();
        img_readonly = 1'b1;
        cyc();
        chk("readonly wps_n", int'(wps_n), 0);
        pulse_mount();
        serve(1'b0, 17, "readonly load", ces);
        mtr = 1'b1; cyc();
        repeat (3) begin
            byte_wr = 1'b1; cyc(); byte_wr = 1'b0; cyc();
        end
        mtr = 1'b0;
        watch_quiet(3 * SC, "readonly no save");
        chk("readonly busy", int'(busy), 0);
        chk("readonly wps_n later", int'(wps_n), 0);

        // Step during LOAD_WAIT: finish, settle, reload; then async reset mid-load
        do_reset();
        pulse_mount();
        ce_auto = 1'b1;
        wait_req(1'b0, 8 * SC + 20, ces, ok, other);
        ce_auto = 1'b0; ce = 1'b0;
        chk("lw first request", int'(ok), 1);
        chk("lw first track", int'(sd_track), 17);
        sd_ack = 1'b1; cyc(); sd_ack = 1'b0;
        mtr = 1'b1;
        step(1'b1);
        step(1'b1);
        chk("lw moved half_track", int'(half_track), 36);
        chk("lw no request while waiting", int'(sd_rd_req | sd_wr_req), 0);
        sd_done = 1'b1; cyc(); sd_done = 1'b0;
        chk("lw busy after done", int'(busy), 1);
        chk("lw no immediate reload", int'(sd_rd_req), 0);
        serve(1'b0, 18, "lw reload", ces);
        chk("lw reload settle ce count", ces, SC);
        chk("lw busy idle", int'(busy), 0);
        pulse_mount();
        ce_auto = 1'b1;
        wait_req(1'b0, 8 * SC + 20, ces, ok, other);
        ce_auto = 1'b0; ce = 1'b0;
        chk("remount request", int'(ok), 1);
        sd_ack = 1'b1; cyc(); sd_ack = 1'b0;
        cyc();
        @(posedge clk32);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async reset sd_rd_req", int'(sd_rd_req), 0);
        chk("async reset sd_wr_req", int'(sd_wr_req), 0);
        chk("async reset busy", int'(busy), 1);
        chk("async reset half_track", int'(half_track), 34);
        chk("async reset sd_track", int'(sd_track), 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Random stepping against a position model
        do_reset();
        pulse_mount();
        serve(1'b0, 17, "random setup load", ces);
        m_ht = 34;
        m_old = 2'd0;
        for (int i = 0; i < 800; i++) begin
            ce = 1'($urandom_range(0, 1));
            mtr = ($urandom_range(0, 7) != 0);
            stp = 2'($urandom);
            img_readonly = 1'($urandom);
            sd_ack = ($urandom_range(0, 7) == 0);
            sd_done = ($urandom_range(0, 7) == 0);
            prev_ht = m_ht;
            prev_rd = sd_rd_req;
            prev_wr = sd_wr_req;
            prev_trk = sd_track;
            @(posedge clk32);
            #1;
            if (ce) begin
                if (mtr) begin
                    if (((int'(stp) - int'(m_old)) & 3) == 1)
                        m_ht = (m_ht < MH) ? m_ht + 1 : MH;
                    else if (((int'(stp) - int'(m_old)) & 3) == 3)
                        m_ht = (m_ht > 0) ? m_ht - 1 : 0;
                end
                m_old = stp;
            end
            chk("rand half_track", int'(half_track), m_ht);
            chk("rand tr00_sense_n", int'(tr00_sense_n), int'(m_ht != 0));
            chk("rand wps_n", int'(wps_n), int'(!img_readonly));
            chk("rand requests exclusive", int'(sd_rd_req & sd_wr_req), 0);
            if (!prev_rd && sd_rd_req)
                chk("rand load track", int'(sd_track), prev_ht / 2);
            if ((prev_rd && sd_rd_req) || (prev_wr && sd_wr_req))
                chk("rand sd_track stable", int'(sd_track), int'(prev_trk));
        end
        sd_ack = 1'b0; sd_done = 1'b0; ce = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
